// File: rtl/softermax_global_norm_if.sv
// Handshake bundle for the softermax global-normalisation stage:
// the per-window input stream and the normalised output stream.
interface softermax_global_norm_if #(
  parameter int PARALLELISM = 4,
  parameter int IN_WIDTH    = 8,
  parameter int MAX_WIDTH   = 4,
  parameter int OUT_WIDTH   = 8
);
  logic [PARALLELISM-1:0][IN_WIDTH-1:0]  in_values;
  logic signed [MAX_WIDTH-1:0]           in_max;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [PARALLELISM-1:0][OUT_WIDTH-1:0] out_data;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output in_values, in_max, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_values, in_max, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/softermax_global_norm.sv
// Softermax stage 2: tracks a running global max and renormalised sum over a vector,
// takes a sequential reciprocal of the sum, then replays buffered windows as probabilities.
module softermax_global_norm #(
  parameter int TOTAL_DIM        = 16,
  parameter int PARALLELISM      = 4,
  parameter int IN_WIDTH         = 8,
  parameter int IN_FRAC_WIDTH    = 7,
  parameter int MAX_WIDTH        = 4,
  parameter int RECIP_FRAC_WIDTH = 8,
  parameter int OUT_WIDTH        = 8,
  parameter int OUT_FRAC_WIDTH   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  softermax_global_norm_if.slave bus
);
  localparam int DEPTH      = TOTAL_DIM / PARALLELISM;
  localparam int ACC_WIDTH  = IN_WIDTH + $clog2(TOTAL_DIM);
  localparam int LSUM_WIDTH = IN_WIDTH + $clog2(PARALLELISM);
  localparam int Q_WIDTH    = IN_FRAC_WIDTH + RECIP_FRAC_WIDTH + 1;
  localparam int PROD_WIDTH = IN_WIDTH + Q_WIDTH;
  localparam int BASE_SHIFT = IN_FRAC_WIDTH + RECIP_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int DCNT_W     = $clog2(Q_WIDTH + 1);

  typedef enum logic [1:0] {ACCUM, RECIP, DRAIN} state_e;
  typedef logic [PARALLELISM-1:0][IN_WIDTH-1:0]  window_t;
  typedef logic [PARALLELISM-1:0][OUT_WIDTH-1:0] beat_t;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            wcnt_q, wcnt_d;
  logic [CNT_W-1:0]            rcnt_q, rcnt_d;
  logic [CNT_W-1:0]            rdIdx_q, rdIdx_d;
  logic [ACC_WIDTH-1:0]        sum_q, sum_d;
  logic signed [MAX_WIDTH-1:0] gmax_q, gmax_d;
  logic [ACC_WIDTH-1:0]        divRem_q, divRem_d;
  logic [Q_WIDTH-1:0]          divDvd_q, divDvd_d;
  logic [Q_WIDTH-1:0]          recip_q, recip_d;
  logic [DCNT_W-1:0]           divCnt_q, divCnt_d;
  beat_t                       outData_q, outData_d;
  logic                        outValid_q, outValid_d;
  logic                        inReady_q;

  window_t                     valBuf [DEPTH];
  logic signed [MAX_WIDTH-1:0] maxBuf [DEPTH];

  logic                        inFire;
  logic                        outFire;
  logic [LSUM_WIDTH-1:0]       lsum;
  logic signed [MAX_WIDTH:0]   inDiff;
  logic [MAX_WIDTH:0]          inShift;
  logic [ACC_WIDTH:0]          divTrial;
  logic                        divGe;
  window_t                     rdVals;
  logic signed [MAX_WIDTH-1:0] rdMax;
  logic [MAX_WIDTH:0]          drainDiff;
  int                          drainShift;
  beat_t                       scaled;

  // Right shift of the accumulator domain; anything at or beyond the width is fully shifted out.
  function automatic logic [ACC_WIDTH-1:0] shrAcc(input logic [ACC_WIDTH-1:0] v,
                                                  input logic [MAX_WIDTH:0]   sh);
    return (int'(sh) >= ACC_WIDTH) ? '0 : (v >> sh);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] scaleLane(input logic [IN_WIDTH-1:0] v,
                                                     input logic [Q_WIDTH-1:0]  r,
                                                     input int                  sh);
    logic [PROD_WIDTH-1:0] prod;
    logic [PROD_WIDTH-1:0] shifted;
    prod    = PROD_WIDTH'(v) * PROD_WIDTH'(r);
    shifted = (sh >= PROD_WIDTH) ? '0 : (prod >> sh);
    if (shifted > PROD_WIDTH'({OUT_WIDTH{1'b1}})) return '1;
    return shifted[OUT_WIDTH-1:0];
  endfunction

  assign inFire  = bus.in_valid && inReady_q;
  assign outFire = outValid_q && bus.out_ready;

  assign inDiff  = {bus.in_max[MAX_WIDTH-1], bus.in_max} - {gmax_q[MAX_WIDTH-1], gmax_q};
  assign inShift = inDiff[MAX_WIDTH] ? -inDiff : inDiff;

  always_comb begin
    lsum = '0;
    for (int l = 0; l < PARALLELISM; l++) begin
      lsum = lsum + LSUM_WIDTH'(bus.in_values[l]);
    end
  end

  // One restoring step per cycle: the remainder stays below sum, so one spare bit suffices.
  assign divTrial = {divRem_q, divDvd_q[Q_WIDTH-1]};
  assign divGe    = divTrial >= {1'b0, sum_q};

  assign rdVals     = valBuf[rdIdx_q[PTR_W-1:0]];
  assign rdMax      = maxBuf[rdIdx_q[PTR_W-1:0]];
  assign drainDiff  = {gmax_q[MAX_WIDTH-1], gmax_q} - {rdMax[MAX_WIDTH-1], rdMax};
  assign drainShift = BASE_SHIFT + int'(drainDiff);

  always_comb begin
    scaled = '0;
    for (int l = 0; l < PARALLELISM; l++) begin
      scaled[l] = scaleLane(rdVals[l], recip_q, drainShift);
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    rdIdx_d    = rdIdx_q;
    sum_d      = sum_q;
    gmax_d     = gmax_q;
    divRem_d   = divRem_q;
    divDvd_d   = divDvd_q;
    recip_d    = recip_q;
    divCnt_d   = divCnt_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;

    unique case (state_q)
      ACCUM: begin
        if (inFire) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (wcnt_q == '0) begin
            gmax_d = bus.in_max;
            sum_d  = ACC_WIDTH'(lsum);
          end else if (inDiff > 0) begin
            gmax_d = bus.in_max;
            sum_d  = shrAcc(sum_q, inShift) + ACC_WIDTH'(lsum);
          end else begin
            sum_d  = sum_q + shrAcc(ACC_WIDTH'(lsum), inShift);
          end
          if (wcnt_q == CNT_W'(DEPTH - 1)) begin
            state_d  = RECIP;
            divRem_d = '0;
            divDvd_d = Q_WIDTH'(1) << (Q_WIDTH - 1);
            divCnt_d = '0;
            recip_d  = '0;
          end
        end
      end

      RECIP: begin
        if (sum_q == '0) begin
          recip_d  = '1;
          divCnt_d = '0;
          rcnt_d   = '0;
          rdIdx_d  = '0;
          state_d  = DRAIN;
        end else begin
          divDvd_d = divDvd_q << 1;
          divRem_d = divGe ? ACC_WIDTH'(divTrial - {1'b0, sum_q}) : divTrial[ACC_WIDTH-1:0];
          recip_d  = {recip_q[Q_WIDTH-2:0], divGe};
          divCnt_d = divCnt_q + DCNT_W'(1);
          if (divCnt_q == DCNT_W'(Q_WIDTH - 1)) begin
            divCnt_d = '0;
            rcnt_d   = '0;
            rdIdx_d  = '0;
            state_d  = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (outFire) begin
          outValid_d = 1'b0;
          rcnt_d     = rcnt_q + CNT_W'(1);
          if (rcnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = ACCUM;
            wcnt_d  = '0;
            sum_d   = '0;
            gmax_d  = '0;
          end
        end
        // Reload as soon as the output slot frees up so a ready sink sees one beat per cycle.
        if ((!outValid_q || bus.out_ready) && (rdIdx_q != CNT_W'(DEPTH))) begin
          outData_d  = scaled;
          outValid_d = 1'b1;
          rdIdx_d    = rdIdx_q + CNT_W'(1);
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      rdIdx_q    <= '0;
      sum_q      <= '0;
      gmax_q     <= '0;
      divRem_q   <= '0;
      divDvd_q   <= '0;
      recip_q    <= '0;
      divCnt_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      rdIdx_q    <= rdIdx_d;
      sum_q      <= sum_d;
      gmax_q     <= gmax_d;
      divRem_q   <= divRem_d;
      divDvd_q   <= divDvd_d;
      recip_q    <= recip_d;
      divCnt_q   <= divCnt_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      inReady_q  <= (state_d == ACCUM);
    end
  end

  always_ff @(posedge clk) begin
    if (inFire) begin
      valBuf[wcnt_q[PTR_W-1:0]] <= bus.in_values;
      maxBuf[wcnt_q[PTR_W-1:0]] <= bus.in_max;
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
endmodule

// File: tb/tb_softermax_global_norm.sv
// Directed bench for softermax_global_norm with an expected-beat queue drained by an output monitor.
module tb_softermax_global_norm;
  localparam int TOTAL_DIM   = 8;
  localparam int PARALLELISM = 4;
  localparam int Q_WIDTH     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  int          beatCount = 0;
  int          lastOutHs = -1;
  int          firstValidCycle = -1;
  logic        firstValidSeen = 1'b1;
  logic        stallPrev = 1'b0;
  logic [31:0] stallData = '0;

  softermax_global_norm_if #(.PARALLELISM(PARALLELISM), .IN_WIDTH(8), .MAX_WIDTH(4), .OUT_WIDTH(8)) bus ();

  softermax_global_norm #(
    .TOTAL_DIM(TOTAL_DIM), .PARALLELISM(PARALLELISM), .IN_WIDTH(8), .IN_FRAC_WIDTH(7),
    .MAX_WIDTH(4), .RECIP_FRAC_WIDTH(8), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, actual, expected, cycle);
    end
  endtask

  // Monitor: every output handshake pops one expected beat; a stalled beat must hold still.
  always @(negedge clk) begin
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_data", bus.out_data, stallData);
      end
      if (bus.out_valid && !firstValidSeen) begin
        firstValidSeen  = 1'b1;
        firstValidCycle = cycle;
      end
      if (bus.out_valid && bus.out_ready) begin
        beatCount++;
        lastOutHs = cycle;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%h expected=none cycle=%0d", bus.out_data, cycle);
        end else begin
          checkOutput("beat", bus.out_data, expQ.pop_front());
        end
      end
      stallPrev = bus.out_valid && !bus.out_ready;
      stallData = bus.out_data;
    end
  end

  task automatic applyStimulus(input logic [31:0] vals, input logic signed [3:0] maxVal, output int hsCycle);
    int budget;
    budget  = 0;
    hsCycle = -1;
    bus.in_values = vals;
    bus.in_max    = maxVal;
    bus.in_valid  = 1'b1;
    while (hsCycle < 0 && budget < 200) begin
      @(negedge clk);
      if (bus.in_ready) hsCycle = cycle;
      budget++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("in_handshake", 32'(hsCycle >= 0), 32'd1);
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain_done", 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pushVector(input logic [31:0] beat0, input logic [31:0] beat1);
    expQ.push_back(beat0);
    expQ.push_back(beat1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs;
    int t;
    int hs3;
    int b0;
    int budget;
    bus.in_values = '0;
    bus.in_max    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", bus.out_data, 32'd0);
    @(posedge clk);
    #1;

    // Equal windows: sum 1024, R 32, every output 0.125.
    pushVector({4{8'd16}}, {4{8'd16}});
    applyStimulus({4{8'd128}}, 4'h0, hs);
    applyStimulus({4{8'd128}}, 4'h0, hs);
    waitDrain();

    // Second window raises the max: sum 768, R 42.
    pushVector({4{8'd10}}, {4{8'd21}});
    applyStimulus({4{8'd128}}, 4'h0, hs);
    applyStimulus({4{8'd128}}, 4'h1, hs);
    waitDrain();

    // Max jumps -8 -> 7: the old sum is shifted out entirely.
    pushVector({4{8'd0}}, {4{8'd32}});
    applyStimulus({4{8'd128}}, 4'h8, hs);
    applyStimulus({4{8'd128}}, 4'h7, hs);
    waitDrain();

    // Back-pressure for five cycles after the first beat.
    pushVector({4{8'd16}}, {4{8'd16}});
    b0 = beatCount;
    applyStimulus({4{8'd128}}, 4'h0, hs);
    applyStimulus({4{8'd128}}, 4'h0, hs);
    budget = 0;
    while (!bus.out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("stall_first_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    waitDrain();
    checkOutput("stall_beat_count", 32'(beatCount - b0), 32'd2);

    // Reset mid-vector discards the partial window; replay must match the equal-window case.
    applyStimulus({4{8'd128}}, 4'h0, hs);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    pushVector({4{8'd16}}, {4{8'd16}});
    applyStimulus({4{8'd128}}, 4'h0, hs);
    applyStimulus({4{8'd128}}, 4'h0, hs);
    waitDrain();

    // Next vector's first window held during RECIP/DRAIN, plus first-output latency.
    pushVector({4{8'd16}}, {4{8'd16}});
    pushVector({4{8'd16}}, {4{8'd16}});
    firstValidSeen = 1'b0;
    applyStimulus({4{8'd128}}, 4'h0, hs);
    applyStimulus({4{8'd128}}, 4'h0, t);
    applyStimulus({4{8'd128}}, 4'h0, hs3);
    checkOutput("held_accept_cycle", 32'(hs3), 32'(lastOutHs + 1));
    checkOutput("first_valid_latency", 32'(firstValidCycle - t), 32'(Q_WIDTH + 2));
    applyStimulus({4{8'd128}}, 4'h0, hs);
    waitDrain();

    // Distinct lanes: sum 696, R 47; checks lane ordering and truncation.
    pushVector({8'd0, 8'd5, 8'd11, 8'd23}, {8'd36, 8'd0, 8'd46, 8'd2});
    applyStimulus({8'd0, 8'd32, 8'd64, 8'd128}, 4'h0, hs);
    applyStimulus({8'd200, 8'd1, 8'd255, 8'd16}, 4'h0, hs);
    waitDrain();

    // Sum collapses to zero: reciprocal forced to all ones, window0 shift 11 -> 31.
    pushVector({4{8'd31}}, {4{8'd0}});
    applyStimulus({4{8'd1}}, 4'h0, hs);
    applyStimulus({4{8'd0}}, 4'h3, hs);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/softermax_global_norm.md
# softermax_global_norm

Second stage of the softermax pipeline. It consumes the per-window stream of power-of-2 values and local integer maxima, one window per beat. Over a full vector of `TOTAL_DIM` elements it tracks a running global maximum and a renormalised running sum. It then computes the reciprocal of the sum with a sequential restoring divider and replays the buffered windows as normalised probabilities.

## Interface
- `TOTAL_DIM`, 16: elements per softmax vector; must be a multiple of `PARALLELISM`.
- `PARALLELISM`, 4: elements per window beat.
- `IN_WIDTH`, 8: unsigned power-of-2 input value width.
- `IN_FRAC_WIDTH`, 7: input fraction bits (F).
- `MAX_WIDTH`, 4: signed local-max width.
- `RECIP_FRAC_WIDTH`, 8: reciprocal fraction bits (RF).
- `OUT_WIDTH`, 8: unsigned output width.
- `OUT_FRAC_WIDTH`, 7: output fraction bits.
- Derived: `DEPTH`=`TOTAL_DIM`/`PARALLELISM`; `ACC_WIDTH`=`IN_WIDTH`+clog2(`TOTAL_DIM`); `Q_WIDTH`=F+RF+1.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_values` in `IN_WIDTH` x `PARALLELISM`: window power-of-2 values, unsigned Q(F).
- `in_max` in `MAX_WIDTH`: window local max, signed integer.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `out_data` out `OUT_WIDTH` x `PARALLELISM`: normalised values, unsigned Q(`OUT_FRAC_WIDTH`).
- `out_valid` out 1 / `out_ready` in 1: output handshake.

## Operation
- The FSM has three states: ACCUM, RECIP, DRAIN. Reset state is ACCUM.
- ACCUM, with `in_ready`=1:
  - On each handshake, compute `lsum` = sum of `in_values`, full width, no loss.
  - Write `in_values` and `in_max` into the buffer at index `wcnt`, which has `DEPTH` entries.
  - First window: gmax←`in_max`, sum←lsum.
  - `in_max`>gmax: sum←(sum>>(`in_max`−gmax))+lsum, and gmax←`in_max`.
  - Otherwise: sum←sum+(lsum>>(gmax−`in_max`)).
  - Differences are signed, `MAX_WIDTH`+1 bits. Any shift ≥`ACC_WIDTH` yields 0.
  - sum is `ACC_WIDTH` bits, Q(F).
  - After handshake number `DEPTH`, go to RECIP.
- RECIP, with `in_ready`=0:
  - Restoring divider produces R=floor(2^(F+RF)/sum), one quotient bit per cycle, `Q_WIDTH` cycles.
  - If sum=0, R=all ones and the divider is skipped.
  - Then go to DRAIN with `rcnt`=0.
- DRAIN, with `in_ready`=0:
  - Load the output register from buffer[`rcnt`].
  - Each lane: out = saturate_`OUT_WIDTH`((v·R) >> (F+RF−`OUT_FRAC_WIDTH`+(gmax−lmax))), truncating.
  - Total shift ≥ product width gives 0.
  - On each output handshake, `rcnt`++. After `DEPTH` handshakes, return to ACCUM and clear `wcnt`, the first-window flag, sum and gmax.
- Storage order equals arrival order. The output order is identical.

## Timing
- Reset values:
  - `in_ready`=1 (state ACCUM).
  - `out_valid`=0 and `out_data`=0.
  - `wcnt`, `rcnt`, sum and gmax are 0.
  - The divider is idle.
- Reset mid-operation, in any state: same values the next cycle. Partial vectors and pending outputs are discarded.
- Input accepted iff `in_valid`&&`in_ready`. `in_ready` is a registered state decode.
  - No combinational path from `in_valid` to `in_ready`.
  - No combinational path from `out_ready` to `in_ready`.
- One window per cycle is sustained in ACCUM.
- Latency: the last input handshake occurs in cycle t. Then:
  - RECIP occupies t+1 .. t+`Q_WIDTH`.
  - `out_valid`=1 at t+`Q_WIDTH`+2.
- `out_data` is registered. It must be held stable while `out_valid`&&!`out_ready`.
- With `out_ready` held high, one beat per cycle is produced, giving `DEPTH` consecutive beats.
- `in_ready` rises the cycle after the last output handshake.
- A new vector cannot overlap the drain. `in_valid` asserted during RECIP/DRAIN is held off, not dropped.

## Test plan
- All beats use `TOTAL_DIM`=8, `PARALLELISM`=4, F=7, RF=8, `OUT_FRAC_WIDTH`=7.
- 1: Two windows, all values 128 (1.0), both max 0 -> sum=1024, R=32, all 8 outputs=16 (0.125).
- 2: Window0 values 128 max 0, window1 values 128 max 1 -> sum=768, R=42; window0 outputs=10, window1 outputs=21.
- 3: Window0 max −8, window1 max 7, values 128 -> old sum shifted out, sum=512, R=64; window0 outputs=0, window1 outputs=32.
- 4: Scenario 1 with `out_ready` low for 5 cycles mid-drain -> `out_data` stable, no beat lost or duplicated, exactly 2 beats total.
- 5: `rst` pulsed after window0 is accepted, then scenario 1 is replayed -> outputs identical to scenario 1. Also check `in_ready`=1 and `out_valid`=0 the cycle after reset.
- 6: Third window presented with `in_valid` held through RECIP/DRAIN -> not accepted until the cycle after the last output handshake. First out_valid exactly `Q_WIDTH`+2=18 cycles after the last input handshake.
